// File: rtl/pcs_rx_lock_ctrl_32b_pkg.sv
// Shared types and defaults for the 10GBASE-R 32b receive block-lock controller.
package pcs_rx_lock_ctrl_32b_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int unsigned SH_WINDOW_DFLT    = 64;
  localparam int unsigned SH_INVLD_MAX_DFLT = 16;
  localparam int unsigned SLIP_WAIT_DFLT    = 32;
  localparam int unsigned BER_WINDOW_DFLT   = 40283;
  localparam int unsigned BER_MAX_DFLT      = 16;
  localparam int unsigned BER_CNT_W         = 6;

  typedef enum logic [1:0] {
    RESET_CNT,
    TEST_SH,
    SLIP,
    WAIT
  } lock_state_t;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_lock_ctrl_32b_if.sv
// Sync-header / slip / status bundle between the block-sync datapath and the lock controller.
interface pcs_rx_lock_ctrl_32b_if;
  import pcs_rx_lock_ctrl_32b_pkg::*;

  logic [1:0]           sh;
  logic                 sh_en;
  logic                 slip;
  logic                 block_lock;
  logic                 hi_ber;
  logic [BER_CNT_W-1:0] ber_cnt;
  logic                 ber_cnt_clr;

  modport master (
    output sh, sh_en, ber_cnt_clr,
    input  slip, block_lock, hi_ber, ber_cnt
  );

  modport slave (
    input  sh, sh_en, ber_cnt_clr,
    output slip, block_lock, hi_ber, ber_cnt
  );

endinterface

// File: rtl/pcs_rx_ber_mon_32b.sv
// hi_ber window monitor and saturating invalid-header counter, active only while locked.
module pcs_rx_ber_mon_32b
  import pcs_rx_lock_ctrl_32b_pkg::*;
#(
  parameter int unsigned BER_WINDOW = BER_WINDOW_DFLT,
  parameter int unsigned BER_MAX    = BER_MAX_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 block_lock,
  input  logic                 sh_bad,
  input  logic                 ber_cnt_clr,
  output logic                 hi_ber,
  output logic [BER_CNT_W-1:0] ber_cnt
);

  localparam int unsigned WIN_W  = $clog2(BER_WINDOW);
  localparam int unsigned BCNT_W = $clog2(BER_MAX + 1);

  logic [WIN_W-1:0]  win_cnt;
  logic [BCNT_W-1:0] ber_win_cnt;
  logic [BCNT_W-1:0] ber_win_upd;
  logic              hit;
  logic              win_end;

  assign hit         = block_lock & sh_bad;
  assign win_end     = (win_cnt == WIN_W'(BER_WINDOW - 1));
  assign ber_win_upd = (hit && (ber_win_cnt != BCNT_W'(BER_MAX))) ?
                       ber_win_cnt + BCNT_W'(1) : ber_win_cnt;

  // Window restarts whenever lock is absent, so each window measures locked time only.
  always_ff @(posedge clk) begin
    if (rst || !block_lock) begin
      win_cnt     <= '0;
      ber_win_cnt <= '0;
      hi_ber      <= 1'b0;
    end else begin
      win_cnt     <= win_end ? '0 : win_cnt + WIN_W'(1);
      ber_win_cnt <= win_end ? '0 : ber_win_upd;
      if (ber_win_upd == BCNT_W'(BER_MAX)) hi_ber <= 1'b1;
      else if (win_end)                    hi_ber <= 1'b0;
    end
  end

  // A clear that lands on a counted header keeps that header.
  always_ff @(posedge clk) begin
    if (rst)                         ber_cnt <= '0;
    else if (ber_cnt_clr)            ber_cnt <= BER_CNT_W'(hit);
    else if (hit && (ber_cnt != '1)) ber_cnt <= ber_cnt + BER_CNT_W'(1);
  end

endmodule

// File: rtl/pcs_rx_lock_ctrl_32b.sv
// Clause 49 block-lock state machine driving slip to the 32b block-sync datapath.
module pcs_rx_lock_ctrl_32b
  import pcs_rx_lock_ctrl_32b_pkg::*;
#(
  parameter int unsigned SH_WINDOW    = SH_WINDOW_DFLT,
  parameter int unsigned SH_INVLD_MAX = SH_INVLD_MAX_DFLT,
  parameter int unsigned SLIP_WAIT    = SLIP_WAIT_DFLT,
  parameter int unsigned BER_WINDOW   = BER_WINDOW_DFLT,
  parameter int unsigned BER_MAX      = BER_MAX_DFLT
) (
  input logic                    clk,
  input logic                    rst,
  pcs_rx_lock_ctrl_32b_if.slave  bus
);

  localparam int unsigned SH_CNT_W = $clog2(SH_WINDOW + 1);
  localparam int unsigned INV_W    = $clog2(SH_INVLD_MAX + 1);
  localparam int unsigned WAIT_W   = $clog2(SLIP_WAIT + 1);

  lock_state_t         state, state_nxt;
  logic [SH_CNT_W-1:0] sh_cnt, sh_cnt_nxt, sh_cnt_inc;
  logic [INV_W-1:0]    invld_cnt, invld_cnt_nxt, invld_cnt_inc;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                slip, slip_nxt;
  logic                lock, lock_nxt;
  logic                sh_bad;

  assign sh_bad        = ~sh_valid(bus.sh);
  assign sh_cnt_inc    = sh_cnt + SH_CNT_W'(1);
  assign invld_cnt_inc = invld_cnt + INV_W'(sh_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_CNT;
      sh_cnt    <= '0;
      invld_cnt <= '0;
      wait_cnt  <= '0;
      slip      <= 1'b0;
      lock      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh_cnt    <= sh_cnt_nxt;
      invld_cnt <= invld_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      slip      <= slip_nxt;
      lock      <= lock_nxt;
    end
  end

  // Window rules judge the counts including the header arriving this cycle.
  always_comb begin
    state_nxt     = state;
    sh_cnt_nxt    = sh_cnt;
    invld_cnt_nxt = invld_cnt;
    wait_cnt_nxt  = wait_cnt;
    slip_nxt      = 1'b0;
    lock_nxt      = lock;
    case (state)
      RESET_CNT: begin
        sh_cnt_nxt    = '0;
        invld_cnt_nxt = '0;
        state_nxt     = TEST_SH;
      end
      TEST_SH: begin
        if (bus.sh_en) begin
          sh_cnt_nxt    = sh_cnt_inc;
          invld_cnt_nxt = invld_cnt_inc;
          if (sh_bad && !lock) begin
            state_nxt = SLIP;
          end else if (invld_cnt_inc == INV_W'(SH_INVLD_MAX)) begin
            lock_nxt  = 1'b0;
            state_nxt = SLIP;
          end else if (sh_cnt_inc == SH_CNT_W'(SH_WINDOW)) begin
            if (invld_cnt_inc == '0) lock_nxt = 1'b1;
            state_nxt = RESET_CNT;
          end
        end
      end
      SLIP: begin
        slip_nxt     = 1'b1;
        wait_cnt_nxt = WAIT_W'(SLIP_WAIT);
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = RESET_CNT;
        else                wait_cnt_nxt = wait_cnt - WAIT_W'(1);
      end
      default: state_nxt = RESET_CNT;
    endcase
  end

  assign bus.slip       = slip;
  assign bus.block_lock = lock;

  pcs_rx_ber_mon_32b #(
    .BER_WINDOW (BER_WINDOW),
    .BER_MAX    (BER_MAX)
  ) u_ber_mon (
    .clk         (clk),
    .rst         (rst),
    .block_lock  (lock),
    .sh_bad      (bus.sh_en & sh_bad),
    .ber_cnt_clr (bus.ber_cnt_clr),
    .hi_ber      (bus.hi_ber),
    .ber_cnt     (bus.ber_cnt)
  );

endmodule

// File: tb/tb_pcs_rx_lock_ctrl_32b.sv
// Scenario bench for pcs_rx_lock_ctrl_32b; slip pulses are scoreboarded by cycle number.
module tb_pcs_rx_lock_ctrl_32b;
  import pcs_rx_lock_ctrl_32b_pkg::*;

  logic clk = 1'b0;
  logic rst;

  pcs_rx_lock_ctrl_32b_if ifc();

  pcs_rx_lock_ctrl_32b #(.BER_WINDOW(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_slip[$];
  int obs_slip[$];

  logic       hdr_lock;
  logic       hdr_hiber;
  logic [5:0] hdr_ber;
  int         hdr_cyc;

  function automatic logic [1:0] vld(input int i);
    return (i % 2 == 0) ? SH_DATA : SH_CTRL;
  endfunction

  function automatic logic [1:0] bad(input int i);
    return (i % 2 == 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.slip === 1'b1) obs_slip.push_back(cyc);
  endtask

  // One header on sh_en, then one idle cycle carrying a junk header that must be ignored.
  task automatic send(input logic [1:0] v, input logic clr);
    ifc.sh = v; ifc.sh_en = 1'b1; ifc.ber_cnt_clr = clr;
    tick();
    hdr_lock = ifc.block_lock; hdr_hiber = ifc.hi_ber; hdr_ber = ifc.ber_cnt; hdr_cyc = cyc;
    ifc.sh = 2'b11; ifc.sh_en = 1'b0; ifc.ber_cnt_clr = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; ifc.sh_en = 1'b0; ifc.ber_cnt_clr = 1'b0; ifc.sh = 2'b11;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ifc.sh_en = 1'b0; ifc.ber_cnt_clr = 1'b0; ifc.sh = 2'b00;
    tick(); tick();
    n_cmp++; if (ifc.slip !== 1'b0) begin n_err++; $display("FAIL reset_slip: got %b want 0", ifc.slip); end
    n_cmp++; if (ifc.block_lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b want 0", ifc.block_lock); end
    n_cmp++; if (ifc.hi_ber !== 1'b0) begin n_err++; $display("FAIL reset_hi_ber: got %b want 0", ifc.hi_ber); end
    n_cmp++; if (ifc.ber_cnt !== 6'd0) begin n_err++; $display("FAIL reset_ber_cnt: got %0d want 0", ifc.ber_cnt); end
    rst = 1'b0;
    tick(); tick();
    obs_slip.delete(); exp_slip.delete();
  endtask

  task automatic test_lock_acq();
    int e, o;
    for (int i = 0; i < 63; i++) send(vld(i), 1'b0);
    n_cmp++; if (ifc.block_lock !== 1'b0) begin n_err++; $display("FAIL acq_early: lock %b after 63 headers, want 0", ifc.block_lock); end
    send(vld(63), 1'b0);
    n_cmp++; if (hdr_lock !== 1'b1) begin n_err++; $display("FAIL acq_lock: lock %b after 64th header, want 1", hdr_lock); end
    e = -1; o = -1;
    if (exp_slip.size() != 0) e = exp_slip.pop_front();
    if (obs_slip.size() != 0) o = obs_slip.pop_front();
    n_cmp++; if (o != e || obs_slip.size() != 0) begin n_err++; $display("FAIL acq_slip: slip cycle %0d (+%0d), want %0d", o, obs_slip.size(), e); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  task automatic test_prelock_slip();
    int e, o;
    do_reset();
    exp_slip.push_back(cyc + 2);
    send(2'b11, 1'b0);
    for (int i = 0; i < 10; i++) send(bad(i), 1'b0);
    repeat (20) tick();
    for (int i = 0; i < 63; i++) send(vld(i), 1'b0);
    n_cmp++; if (ifc.block_lock !== 1'b0) begin n_err++; $display("FAIL relock_early: lock %b after 63 headers, want 0", ifc.block_lock); end
    send(vld(63), 1'b0);
    n_cmp++; if (hdr_lock !== 1'b1) begin n_err++; $display("FAIL relock: lock %b after 64th header, want 1", hdr_lock); end
    e = -1; o = -1;
    if (exp_slip.size() != 0) e = exp_slip.pop_front();
    if (obs_slip.size() != 0) o = obs_slip.pop_front();
    n_cmp++; if (o != e || obs_slip.size() != 0) begin n_err++; $display("FAIL prelock_slip: slip cycle %0d (+%0d), want %0d", o, obs_slip.size(), e); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  task automatic test_tolerated();
    int e, o;
    for (int i = 0; i < 64; i++) send(((i % 4 == 1) && (i < 60)) ? bad(i) : vld(i), 1'b0);
    n_cmp++; if (hdr_lock !== 1'b1) begin n_err++; $display("FAIL tol_lock: lock %b, want 1", hdr_lock); end
    n_cmp++; if (ifc.ber_cnt !== 6'd15) begin n_err++; $display("FAIL tol_ber_cnt: got %0d want 15", ifc.ber_cnt); end
    n_cmp++; if (ifc.hi_ber !== 1'b0) begin n_err++; $display("FAIL tol_hi_ber: got %b want 0", ifc.hi_ber); end
    e = -1; o = -1;
    if (exp_slip.size() != 0) e = exp_slip.pop_front();
    if (obs_slip.size() != 0) o = obs_slip.pop_front();
    n_cmp++; if (o != e || obs_slip.size() != 0) begin n_err++; $display("FAIL tol_slip: slip cycle %0d (+%0d), want %0d", o, obs_slip.size(), e); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  // 15 bad headers up front, then the 64th header is the 16th bad one.
  task automatic test_loss_of_lock();
    int e, o;
    for (int i = 0; i < 63; i++) begin
      send((i < 15) ? bad(i) : vld(i), i == 0);
      if (i == 0) begin
        n_cmp++; if (hdr_ber !== 6'd1) begin n_err++; $display("FAIL clr_with_inc: ber_cnt %0d want 1", hdr_ber); end
        n_cmp++; if (hdr_hiber !== 1'b1) begin n_err++; $display("FAIL hi_ber_16th: hi_ber %b want 1", hdr_hiber); end
      end
    end
    n_cmp++; if (ifc.block_lock !== 1'b1) begin n_err++; $display("FAIL loss_early: lock %b after 63 headers, want 1", ifc.block_lock); end
    exp_slip.push_back(cyc + 2);
    send(2'b00, 1'b0);
    n_cmp++; if (hdr_lock !== 1'b0) begin n_err++; $display("FAIL loss_priority: lock %b want 0", hdr_lock); end
    n_cmp++; if (hdr_ber !== 6'd16) begin n_err++; $display("FAIL loss_ber_cnt: got %0d want 16", hdr_ber); end
    n_cmp++; if (ifc.hi_ber !== 1'b0) begin n_err++; $display("FAIL loss_hi_ber: got %b want 0", ifc.hi_ber); end
    e = -1; o = -1;
    if (exp_slip.size() != 0) e = exp_slip.pop_front();
    if (obs_slip.size() != 0) o = obs_slip.pop_front();
    n_cmp++; if (o != e || obs_slip.size() != 0) begin n_err++; $display("FAIL loss_slip: slip cycle %0d (+%0d), want %0d", o, obs_slip.size(), e); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  // Entered straight after the loss-of-lock slip, so the controller is in WAIT.
  task automatic test_reset_in_wait();
    int e, o;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (ifc.slip !== 1'b0) begin n_err++; $display("FAIL rstw_slip: got %b want 0", ifc.slip); end
    n_cmp++; if (ifc.block_lock !== 1'b0) begin n_err++; $display("FAIL rstw_lock: got %b want 0", ifc.block_lock); end
    n_cmp++; if (ifc.ber_cnt !== 6'd0) begin n_err++; $display("FAIL rstw_ber_cnt: got %0d want 0", ifc.ber_cnt); end
    rst = 1'b0;
    tick(); tick();
    for (int i = 0; i < 63; i++) send(vld(i), 1'b0);
    n_cmp++; if (ifc.block_lock !== 1'b0) begin n_err++; $display("FAIL rstw_early: lock %b after 63 headers, want 0", ifc.block_lock); end
    send(vld(63), 1'b0);
    n_cmp++; if (hdr_lock !== 1'b1) begin n_err++; $display("FAIL rstw_relock: lock %b after 64th header, want 1", hdr_lock); end
    e = -1; o = -1;
    if (exp_slip.size() != 0) e = exp_slip.pop_front();
    if (obs_slip.size() != 0) o = obs_slip.pop_front();
    n_cmp++; if (o != e || obs_slip.size() != 0) begin n_err++; $display("FAIL rstw_slip_sb: slip cycle %0d (+%0d), want %0d", o, obs_slip.size(), e); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  task automatic test_reset_pending_slip();
    do_reset();
    ifc.sh = 2'b11; ifc.sh_en = 1'b1;
    tick();
    ifc.sh_en = 1'b0; rst = 1'b1;
    tick();
    n_cmp++; if (ifc.slip !== 1'b0) begin n_err++; $display("FAIL pend_slip: got %b want 0", ifc.slip); end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (obs_slip.size() != 0) begin n_err++; $display("FAIL pend_slip_sb: %0d slip pulses, want 0", obs_slip.size()); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  // BER window is 1000 cycles and restarts at the lock-rise edge L; ends fall on L+1000, L+2000.
  task automatic test_hi_ber();
    int l, nerr;
    do_reset();
    for (int i = 0; i < 64; i++) send(vld(i), 1'b0);
    l = hdr_cyc;
    n_cmp++; if (hdr_lock !== 1'b1) begin n_err++; $display("FAIL hb_lock: got %b want 1", hdr_lock); end
    nerr = 0;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 64; i++) begin
        send((i < 15) ? bad(i) : vld(i), 1'b0);
        if (i < 15) begin
          nerr++;
          if (nerr == 15) begin
            n_cmp++; if (hdr_hiber !== 1'b0) begin n_err++; $display("FAIL hb_15: hi_ber %b want 0", hdr_hiber); end
          end
          if (nerr == 16) begin
            n_cmp++; if (hdr_hiber !== 1'b1) begin n_err++; $display("FAIL hb_16: hi_ber %b want 1", hdr_hiber); end
          end
        end
      end
    end
    n_cmp++; if (ifc.ber_cnt !== 6'd63) begin n_err++; $display("FAIL ber_cnt_sat: got %0d want 63", ifc.ber_cnt); end
    n_cmp++; if (ifc.block_lock !== 1'b1) begin n_err++; $display("FAIL hb_keep_lock: got %b want 1", ifc.block_lock); end
    while (cyc < l + 1005) tick();
    n_cmp++; if (ifc.hi_ber !== 1'b1) begin n_err++; $display("FAIL hb_win1_end: hi_ber %b want 1", ifc.hi_ber); end
    for (int i = 0; i < 64; i++) send((i == 10 || i == 20 || i == 30) ? bad(i) : vld(i), 1'b0);
    while (cyc < l + 1995) tick();
    n_cmp++; if (ifc.hi_ber !== 1'b1) begin n_err++; $display("FAIL hb_win2_mid: hi_ber %b want 1", ifc.hi_ber); end
    while (cyc < l + 2001) tick();
    n_cmp++; if (ifc.hi_ber !== 1'b0) begin n_err++; $display("FAIL hb_win2_end: hi_ber %b want 0", ifc.hi_ber); end
    n_cmp++; if (ifc.ber_cnt !== 6'd63) begin n_err++; $display("FAIL ber_cnt_hold: got %0d want 63", ifc.ber_cnt); end
    ifc.ber_cnt_clr = 1'b1;
    tick();
    ifc.ber_cnt_clr = 1'b0;
    n_cmp++; if (ifc.ber_cnt !== 6'd0) begin n_err++; $display("FAIL ber_cnt_clr: got %0d want 0", ifc.ber_cnt); end
    n_cmp++; if (obs_slip.size() != 0) begin n_err++; $display("FAIL hb_slip_sb: %0d slip pulses, want 0", obs_slip.size()); end
    obs_slip.delete(); exp_slip.delete();
  endtask

  initial begin
    rst = 1'b1;
    ifc.sh = 2'b00; ifc.sh_en = 1'b0; ifc.ber_cnt_clr = 1'b0;
    test_reset();
    test_lock_acq();
    test_prelock_slip();
    test_tolerated();
    test_loss_of_lock();
    test_reset_in_wait();
    test_reset_pending_slip();
    test_hi_ber();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pcs_rx_lock_ctrl_32b.md
Name: pcs_rx_lock_ctrl_32b

Overview:
- Controller that sequences 66b block alignment for the 32-bit 10GBASE-R receive path.
- Watches the 2-bit sync header recovered once per 66b block by the 32b block-sync datapath.
- Drives the slip request back to that datapath, following the IEEE 802.3 clause 49 lock state machine.
- Reports block_lock and hi_ber to the decoder-reset logic and to status.

Parameters:
- SH_WINDOW, 64, headers examined per lock test window.
- SH_INVLD_MAX, 16, invalid headers in one window that force loss of lock.
- SLIP_WAIT, 32, clk cycles slip input is ignored after a slip pulse (datapath realignment latency).
- BER_WINDOW, 40283, clk cycles per hi-BER window (125 us at 322.27 MHz).
- BER_MAX, 16, invalid headers in one BER window that assert hi_ber.

Ports:
- clk  in  1  PCS RX clock (one clock)
- rst  in  1  synchronous, active-high reset
- sh  in  2  sync header of the current block
- sh_en  in  1  sh valid this cycle (one pulse per 66b block)
- slip  out  1  one-cycle request to shift datapath alignment by one bit
- block_lock  out  1  clause 49 block_lock
- hi_ber  out  1  high bit-error-rate indication
- ber_cnt  out  6  saturating count of invalid headers while locked; clears on read pulse
- ber_cnt_clr  in  1  clears ber_cnt next cycle

Behaviour:
- Header validity: sh==2'b01 or 2'b10 is valid; 2'b00 or 2'b11 is invalid. sh is ignored when sh_en=0.
- Reset values: slip=0, block_lock=0, hi_ber=0, ber_cnt=0, all counters 0, state=RESET_CNT.
- States:
  - RESET_CNT: sh_cnt=0, sh_invld_cnt=0; go to TEST_SH next cycle.
  - TEST_SH: on sh_en, update the counters. Valid header: sh_cnt++. Invalid header: sh_cnt++ and sh_invld_cnt++.
  - TEST_SH transitions, evaluated on the incremented counter values in the same cycle:
    - Invalid header while block_lock=0: go to SLIP.
    - sh_invld_cnt reaches SH_INVLD_MAX: block_lock<=0, go to SLIP.
    - sh_cnt reaches SH_WINDOW with sh_invld_cnt==0: block_lock<=1, go to RESET_CNT.
    - sh_cnt reaches SH_WINDOW with 0 < sh_invld_cnt < SH_INVLD_MAX: go to RESET_CNT, block_lock unchanged.
  - SLIP: slip=1 for exactly one cycle; load wait counter with SLIP_WAIT; go to WAIT.
  - WAIT: sh_en ignored; count down; at 0 go to RESET_CNT.
- Priority when both apply in one cycle: the SH_INVLD_MAX rule beats the SH_WINDOW rule.
- Latency: slip is asserted 2 cycles after the sh_en carrying the offending header. block_lock rises 1 cycle after the 64th valid header.
- hi_ber monitor (independent free-running window counter):
  - When block_lock=1 and sh_en with an invalid header: ber_win_cnt++ (saturates at BER_MAX).
  - ber_win_cnt reaching BER_MAX: hi_ber<=1 immediately.
  - At window end (counter = BER_WINDOW-1): if ber_win_cnt<BER_MAX then hi_ber<=0; ber_win_cnt<=0; window restarts.
  - block_lock=0 forces hi_ber=0, ber_win_cnt=0, and restarts the window.
- ber_cnt: increments on each invalid header while locked; saturates at 63.
  - ber_cnt_clr coinciding with an increment: result is 1.
- rst mid-operation: everything returns to reset values next cycle, including an in-progress WAIT. A pending slip is dropped.

Decomposition:
- Shared package gtype: constants SH_DATA=2'b01 and SH_CTRL=2'b10, plus the state enum typedef lock_state_t.
- One natural sub-module: pcs_rx_ber_mon_32b, holding the hi_ber window counter and ber_cnt.

Test Plan:
- Lock acquisition: 64 consecutive valid sh (alternating 01/10) on sh_en every 2nd cycle, after rst -> block_lock=1 one cycle after the 64th header; slip never asserted.
- Pre-lock invalid header: first sh=2'b11 after rst -> slip=1 for one cycle, 2 cycles later. Then 32 cycles of sh_en ignored, then a new test window starts.
- Tolerated errors while locked: 15 invalid headers in one 64-header window -> block_lock stays 1; ber_cnt=15; no slip.
- Loss of lock: 16 invalid headers within a window -> block_lock=0 and slip pulse on the 16th. With invalid headers as the 16th and 64th, SH_INVLD_MAX wins.
- hi_ber: BER_WINDOW overridden to 1000; 16 invalid headers inside one window -> hi_ber=1. Next window with 3 errors -> hi_ber=0 at window end.
- Reset in WAIT: assert rst 10 cycles into WAIT -> next cycle slip=0, block_lock=0, state RESET_CNT. Lock is reacquired after 64 valid headers.
